registru_cmd_seq: RTL and testbench
===================================

Name: registru_cmd_seq

Overview:
- Command sequencer that drives the control side of the 4-bit load/inc/dec/shift register. It buffers software/testbench commands in a small FIFO and issues each as a one-cycle control pulse (EN/INC/DEC/SHR/SHL/RST_OUT).
- Keeps a shadow copy of the expected register value and checks the register's returned dataout after every command, flagging mismatches.
- Sits between a command source and one register instance.

Parameters:
- WIDTH, 4, data width of register and shadow.
- DEPTH, 4, command FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- RESET  in  1  reset: synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; = (count < DEPTH).
- cmd_op  in  3  opcode:
  - 0 NOP, 1 LOAD, 2 INC, 3 DEC, 4 SHR, 5 SHL, 6 CLR.
  - 7 is reserved and is treated as NOP.
- cmd_data  in  WIDTH  load value; used only by LOAD.
- EN  out  1  to register EN (LOAD).
- INC  out  1  to register INC.
- DEC  out  1  to register DEC.
- SHR  out  1  to register SHR.
- SHL  out  1  to register SHL.
- RST_OUT  out  1  to register RESET (CLR).
- datain  out  WIDTH  to register datain.
- dataout_in  in  WIDTH  register dataout fed back.
- busy  out  1  state ≠ IDLE or FIFO non-empty.
- shadow  out  WIDTH  expected register value.
- err  out  1  sticky mismatch flag.
- err_count  out  8  mismatch count, saturating at 255.

Behaviour:
- Reset (RESET high at an edge):
  - FIFO emptied; state=IDLE.
  - All control outputs 0; datain=0; shadow=0.
  - err=0; err_count=0; busy=0.
  - Reset mid-command aborts that command; no check is performed for it.
- FIFO:
  - Push on cmd_valid && cmd_ready.
  - When full, cmd_ready=0 even if a pop occurs the same cycle (no pass-through).
  - Pop happens only on the IDLE→ISSUE or CHECK→ISSUE transition.
  - Order is preserved.
- FSM, 3 states:
  - IDLE: if FIFO non-empty → pop head into cur_op/cur_data registers, go to ISSUE.
  - ISSUE (exactly 1 cycle):
    - Exactly one control line high per the decode below; NOP/reserved drives none.
    - datain=cur_data for LOAD, else 0.
    - At the ending edge, shadow updates with the same arithmetic as the register. Go to CHECK.
  - CHECK (1 cycle):
    - Compare dataout_in with shadow. On mismatch, at the ending edge: err←1 and err_count←err_count+1 (saturating).
    - Then go to ISSUE (popping the next command) if the FIFO is non-empty, else IDLE.
- Decode:
  - LOAD→EN, INC→INC, DEC→DEC, SHR→SHR, SHL→SHL, CLR→RST_OUT.
  - Never more than one line high.
  - Outputs are driven only from registered state/cur_op; there is no combinational path from cmd_* to the control outputs.
- Shadow arithmetic, modulo 2^WIDTH:
  - LOAD: shadow=data.
  - INC: +1, so 15→0 wraps.
  - DEC: −1, so 0→15 wraps.
  - SHR: logical right shift, MSB←0.
  - SHL: left shift, LSB←0, MSB dropped.
  - CLR: 0.
  - NOP: unchanged; it is still checked.
- Latency:
  - Command accepted in cycle N → IDLE sees it in N+1 → ISSUE in N+2 → CHECK in N+3.
  - Back-to-back queued commands: one per 2 cycles (ISSUE, CHECK, ISSUE, …).
- Simultaneous push and pop: allowed when not full; count is unchanged.
- err is cleared only by RESET.

Test Plan:
- Reset, then LOAD 4'hA, INC, INC pushed back-to-back → EN pulses in 1 cycle with datain=A. Register goes A, B, C; shadow matches; err=0. ISSUE cycles are 2 apart.
- LOAD 4'hF, INC; then LOAD 0, DEC → wrap: shadow 0 after INC, 15 after DEC; no error.
- LOAD 4'b1001, SHR, SHL, SHL → values 1001, 0100, 1000, 0000; only one control line high per ISSUE.
- Fill 4 commands while the sequencer is stalled → cmd_ready=0 at count 4; the 5th cmd_valid is not accepted. The FIFO drains in order and cmd_ready returns high after the first pop.
- Force dataout_in to 4'h3 during the CHECK of LOAD 4'h5 → err=1, err_count=1. Subsequent good commands leave err high and the count unchanged. Repeat 300 forced mismatches → err_count saturates at 255.
- Assert RESET during ISSUE of INC → next cycle all controls 0, shadow=0, FIFO empty, err=0; no spurious check. Opcode 7 → no control line, shadow unchanged.

Source files
------------

// File: rtl/registru_cmd_seq.sv
// rtl/registru_cmd_seq.sv - command FIFO and sequencer for the 4-bit load/inc/dec/shift register
// Issues one control pulse per queued command and checks the returned value against a shadow copy.
module registru_cmd_seq #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             EN,
    output logic             INC,
    output logic             DEC,
    output logic             SHR,
    output logic             SHL,
    output logic             RST_OUT,
    output logic [WIDTH-1:0] datain,
    input  logic [WIDTH-1:0] dataout_in,
    output logic             busy,
    output logic [WIDTH-1:0] shadow,
    output logic             err,
    output logic [7:0]       err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_INC  = 3'd2;
    localparam logic [2:0] OP_DEC  = 3'd3;
    localparam logic [2:0] OP_SHR  = 3'd4;
    localparam logic [2:0] OP_SHL  = 3'd5;
    localparam logic [2:0] OP_CLR  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CHECK} state_t;

    state_t            state;
    logic [2:0]        fifo_op   [DEPTH];
    logic [WIDTH-1:0]  fifo_data [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       count;
    logic [2:0]        cur_op;
    logic [WIDTH-1:0]  cur_data;
    logic [2:0]        head_op;
    logic [WIDTH-1:0]  head_data;
    logic              push;
    logic              pop;

    assign cmd_ready = (count < FULL_COUNT);
    assign push      = cmd_valid && cmd_ready;
    // A pop only ever launches a new ISSUE, so it is allowed from IDLE or CHECK.
    assign pop       = (state != S_ISSUE) && (count != '0);
    assign head_op   = fifo_op[rd_ptr];
    assign head_data = fifo_data[rd_ptr];
    assign busy      = (state != S_IDLE) || (count != '0);

    function automatic logic [WIDTH-1:0] next_shadow(input logic [2:0] op,
                                                     input logic [WIDTH-1:0] data,
                                                     input logic [WIDTH-1:0] cur);
        case (op)
            OP_LOAD: return data;
            OP_INC:  return cur + WIDTH'(1);
            OP_DEC:  return cur - WIDTH'(1);
            OP_SHR:  return cur >> 1;
            OP_SHL:  return cur << 1;
            OP_CLR:  return '0;
            default: return cur;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (RESET) begin
            state     <= S_IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            cur_op    <= '0;
            cur_data  <= '0;
            EN        <= 1'b0;
            INC       <= 1'b0;
            DEC       <= 1'b0;
            SHR       <= 1'b0;
            SHL       <= 1'b0;
            RST_OUT   <= 1'b0;
            datain    <= '0;
            shadow    <= '0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            if (push) begin
                fifo_op[wr_ptr]   <= cmd_op;
                fifo_data[wr_ptr] <= cmd_data;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase

            // Control pulses are registered at the pop edge so they cover exactly the ISSUE cycle.
            EN      <= 1'b0;
            INC     <= 1'b0;
            DEC     <= 1'b0;
            SHR     <= 1'b0;
            SHL     <= 1'b0;
            RST_OUT <= 1'b0;
            datain  <= '0;
            if (pop) begin
                cur_op   <= head_op;
                cur_data <= head_data;
                EN       <= (head_op == OP_LOAD);
                INC      <= (head_op == OP_INC);
                DEC      <= (head_op == OP_DEC);
                SHR      <= (head_op == OP_SHR);
                SHL      <= (head_op == OP_SHL);
                RST_OUT  <= (head_op == OP_CLR);
                datain   <= (head_op == OP_LOAD) ? head_data : '0;
            end

            case (state)
                S_IDLE: begin
                    if (pop) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    shadow <= next_shadow(cur_op, cur_data, shadow);
                    state  <= S_CHECK;
                end
                S_CHECK: begin
                    if (dataout_in != shadow) begin
                        err <= 1'b1;
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                    end
                    state <= pop ? S_ISSUE : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_registru_cmd_seq.sv
// tb/tb_registru_cmd_seq.sv - self-checking bench for registru_cmd_seq
// Includes a behavioural model of the 4-bit register driving dataout_in.
module tb_registru_cmd_seq;

    localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, INCO = 3'd2, DECO = 3'd3,
                           SHRO = 3'd4, SHLO = 3'd5, CLR = 3'd6, RSV = 3'd7;
    localparam logic [5:0] C_EN = 6'b100000, C_INC = 6'b010000, C_DEC = 6'b001000,
                           C_SHR = 6'b000100, C_SHL = 6'b000010, C_RST = 6'b000001;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [3:0] cmd_data = '0;
    logic       EN, INC, DEC, SHR, SHL, RST_OUT;
    logic [3:0] datain;
    logic [3:0] dataout_in;
    logic       busy;
    logic [3:0] shadow;
    logic       err;
    logic [7:0] err_count;

    logic [3:0] reg_q;
    logic       force_en = 1'b0;
    logic [3:0] force_val = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;

    int         q_cyc[$];
    logic [5:0] q_ctrl[$];
    logic [3:0] q_din[$];

    typedef struct {
        logic [2:0] op;
        logic [3:0] data;
        logic [3:0] exp_shadow;
        logic [5:0] exp_ctrl;
    } vec_t;
    vec_t tbl[12];

    registru_cmd_seq #(.WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .RESET(RESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .EN(EN), .INC(INC), .DEC(DEC),
        .SHR(SHR), .SHL(SHL), .RST_OUT(RST_OUT), .datain(datain),
        .dataout_in(dataout_in), .busy(busy), .shadow(shadow), .err(err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (RESET || RST_OUT) reg_q <= '0;
        else if (EN)          reg_q <= datain;
        else if (INC)         reg_q <= reg_q + 4'd1;
        else if (DEC)         reg_q <= reg_q - 4'd1;
        else if (SHR)         reg_q <= {1'b0, reg_q[3:1]};
        else if (SHL)         reg_q <= {reg_q[2:0], 1'b0};
    end

    assign dataout_in = force_en ? force_val : reg_q;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [5:0] ctrl;
        ctrl = {EN, INC, DEC, SHR, SHL, RST_OUT};
        if (!RESET && ctrl != 6'b0) begin
            chk("onehot_ctrl", $countones(ctrl), 1);
            q_cyc.push_back(cyc);
            q_ctrl.push_back(ctrl);
            q_din.push_back(datain);
        end
    end

    task automatic clear_q();
        q_cyc.delete();
        q_ctrl.delete();
        q_din.delete();
    endtask

    // Called and returns at a falling edge; back-to-back calls push on consecutive cycles.
    task automatic push(input logic [2:0] op, input logic [3:0] data);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", cmd_ready, 1);
        acc_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_bound", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=%0d expected=0", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int acc0;
        int idx;
        int low;
        int n;
        logic [2:0] f_op[8];
        logic [3:0] f_data[8];
        logic [5:0] f_ctrl[8];

        tbl[0]  = '{LOAD, 4'hF, 4'hF, C_EN};
        tbl[1]  = '{INCO, 4'h0, 4'h0, C_INC};
        tbl[2]  = '{LOAD, 4'h0, 4'h0, C_EN};
        tbl[3]  = '{DECO, 4'h0, 4'hF, C_DEC};
        tbl[4]  = '{LOAD, 4'h9, 4'h9, C_EN};
        tbl[5]  = '{SHRO, 4'h0, 4'h4, C_SHR};
        tbl[6]  = '{SHLO, 4'h0, 4'h8, C_SHL};
        tbl[7]  = '{SHLO, 4'h0, 4'h0, C_SHL};
        tbl[8]  = '{LOAD, 4'h6, 4'h6, C_EN};
        tbl[9]  = '{RSV,  4'hA, 4'h6, 6'b0};
        tbl[10] = '{NOP,  4'h0, 4'h6, 6'b0};
        tbl[11] = '{CLR,  4'h0, 4'h0, C_RST};

        f_op   = '{LOAD, INCO, INCO, DECO, SHLO, SHRO, INCO, INCO};
        f_data = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        f_ctrl = '{C_EN, C_INC, C_INC, C_DEC, C_SHL, C_SHR, C_INC, C_INC};

        // Reset state
        repeat (3) @(negedge clk);
        RESET = 1'b0;
        chk("rst_ctrl", {EN, INC, DEC, SHR, SHL, RST_OUT}, 0);
        chk("rst_datain", datain, 0);
        chk("rst_shadow", shadow, 0);
        chk("rst_err", err, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);

        // Back-to-back LOAD A, INC, INC: latency and 2-cycle issue spacing
        clear_q();
        push(LOAD, 4'hA);
        acc0 = acc_cyc;
        push(INCO, 4'h0);
        push(INCO, 4'h0);
        wait_idle();
        chk("b2b_pulses", q_ctrl.size(), 3);
        if (q_ctrl.size() >= 3) begin
            chk("b2b_first_en", q_ctrl[0], C_EN);
            chk("b2b_datain", q_din[0], 4'hA);
            chk("b2b_latency", q_cyc[0] - acc0, 2);
            chk("b2b_space1", q_cyc[1] - q_cyc[0], 2);
            chk("b2b_space2", q_cyc[2] - q_cyc[1], 2);
            chk("b2b_inc_datain", q_din[1], 0);
        end
        chk("b2b_shadow", shadow, 4'hC);
        chk("b2b_reg", reg_q, 4'hC);
        chk("b2b_err", err, 0);

        // Table: single commands, wrap, shifts, reserved opcode, NOP, CLR
        for (int i = 0; i < 12; i++) begin
            clear_q();
            push(tbl[i].op, tbl[i].data);
            wait_idle();
            chk($sformatf("tbl%0d_shadow", i), shadow, tbl[i].exp_shadow);
            chk($sformatf("tbl%0d_err", i), err, 0);
            if (tbl[i].exp_ctrl == 6'b0) begin
                chk($sformatf("tbl%0d_no_pulse", i), q_ctrl.size(), 0);
            end else begin
                chk($sformatf("tbl%0d_pulses", i), q_ctrl.size(), 1);
                if (q_ctrl.size() == 1) begin
                    chk($sformatf("tbl%0d_ctrl", i), q_ctrl[0], tbl[i].exp_ctrl);
                    chk($sformatf("tbl%0d_datain", i), q_din[0],
                        (tbl[i].exp_ctrl == C_EN) ? tbl[i].data : 4'h0);
                end
            end
        end

        // Fill the FIFO faster than it drains; full lasts exactly one cycle, no pass-through
        clear_q();
        idx = 0;
        low = 0;
        n = 0;
        while (idx < 8 && n < 100) begin
            cmd_valid = 1'b1;
            cmd_op    = f_op[idx];
            cmd_data  = f_data[idx];
            if (cmd_ready) idx++;
            else low++;
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        wait_idle();
        chk("fill_accepted", idx, 8);
        chk("fill_full_cycles", low, 1);
        chk("fill_pulses", q_ctrl.size(), 8);
        if (q_ctrl.size() == 8) begin
            for (int i = 0; i < 8; i++) chk($sformatf("fill_order%0d", i), q_ctrl[i], f_ctrl[i]);
        end
        chk("fill_shadow", shadow, 4'h4);
        chk("fill_err", err, 0);

        // Forced mismatch on LOAD 5, then sticky err and saturating count
        force_val = 4'h3;
        force_en  = 1'b1;
        push(LOAD, 4'h5);
        wait_idle();
        force_en = 1'b0;
        chk("mm_err", err, 1);
        chk("mm_count", err_count, 1);
        chk("mm_shadow", shadow, 4'h5);
        push(INCO, 4'h0);
        wait_idle();
        chk("mm_sticky_err", err, 1);
        chk("mm_count_hold", err_count, 1);
        chk("mm_shadow_inc", shadow, 4'h6);
        force_en = 1'b1;
        for (int i = 0; i < 100; i++) push(NOP, 4'h0);
        wait_idle();
        chk("mm_count_101", err_count, 101);
        for (int i = 0; i < 200; i++) push(NOP, 4'h0);
        wait_idle();
        force_en = 1'b0;
        chk("mm_count_sat", err_count, 255);
        chk("mm_err_sat", err, 1);

        // Reset during ISSUE of INC
        push(LOAD, 4'h7);
        wait_idle();
        push(INCO, 4'h0);
        n = 0;
        while (!INC && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rmid_saw_inc", INC, 1);
        RESET = 1'b1;
        @(negedge clk);
        chk("rmid_ctrl", {EN, INC, DEC, SHR, SHL, RST_OUT}, 0);
        chk("rmid_shadow", shadow, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_err", err, 0);
        chk("rmid_err_count", err_count, 0);
        chk("rmid_ready", cmd_ready, 1);
        RESET = 1'b0;
        clear_q();
        repeat (5) @(negedge clk);
        chk("rmid_no_pulse", q_ctrl.size(), 0);
        chk("rmid_no_check", err, 0);
        push(LOAD, 4'h3);
        wait_idle();
        chk("post_shadow", shadow, 4'h3);
        chk("post_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
